// File: rtl/crc_stream_engine.sv
// Handshaked streaming CRC engine: any width/poly, 1..DATA_W bits per clock.
// Define CRC_CHECK_EN to add the crc_ok residue-check output.
module crc_stream_engine #(
  parameter int             CRC_W        = 8,
  parameter logic [CRC_W-1:0] POLY       = 8'h31,
  parameter logic [CRC_W-1:0] INIT       = '0,
  parameter int             DATA_W       = 8,
  parameter int             BITS_PER_CYC = 1,
  parameter int             LSB_FIRST    = 1,
  parameter logic [CRC_W-1:0] CHECK_RES  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out
`ifdef CRC_CHECK_EN
  ,
  output logic              crc_ok
`endif
);

  localparam int STEPS = DATA_W / BITS_PER_CYC;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (BITS_PER_CYC < 1 || (DATA_W % BITS_PER_CYC) != 0) begin : g_bad_cfg
    $error("BITS_PER_CYC must divide DATA_W");
  end

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  localparam logic [CRC_W-1:0] POLY_R = bitrev(POLY);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [CRC_W-1:0]   crc, crc_fold;
  logic [DATA_W-1:0]  sh;
  logic               last_q;
  logic [CNT_W-1:0]   cnt;
  logic               take, final_step;

  assign in_ready   = (state == IDLE) && !clear;
  assign busy       = (state == SHIFT);
  assign crc_valid  = (state == DONE);
  assign take       = in_valid && in_ready;
  assign final_step = busy && (cnt == CNT_W'(1));

  // Fold this cycle's slice of the latched beat, first bit first.
  always_comb begin
    crc_fold = crc;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (LSB_FIRST != 0)
        crc_fold = (crc_fold >> 1) ^
          ((crc_fold[0] ^ sh[i]) ? POLY_R : '0);
      else
        crc_fold = (crc_fold << 1) ^
          ((crc_fold[CRC_W-1] ^ sh[DATA_W-1-i]) ? POLY : '0);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (take) state_n = SHIFT;
      SHIFT: if (final_step) state_n = last_q ? DONE : IDLE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc     <= INIT;
      sh      <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      crc_out <= '0;
`ifdef CRC_CHECK_EN
      crc_ok  <= 1'b0;
`endif
    end else if (clear) begin
      crc <= INIT;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            sh     <= in_data;
            last_q <= in_last;
            cnt    <= CNT_W'(STEPS);
          end
        end
        SHIFT: begin
          crc <= crc_fold;
          cnt <= cnt - CNT_W'(1);
          if (LSB_FIRST != 0) sh <= sh >> BITS_PER_CYC;
          else                sh <= sh << BITS_PER_CYC;
          // Result is published on entry to DONE so it pairs with crc_valid.
          if (final_step && last_q) begin
            crc_out <= crc_fold;
`ifdef CRC_CHECK_EN
            crc_ok  <= (crc_fold == CHECK_RES);
`endif
          end
        end
        DONE: crc <= INIT;
        default: crc <= INIT;
      endcase
    end
  end

endmodule
